// File: rtl/dp_sequencer.sv
// Macro-instruction sequencer for the 8x16 register-file datapath: expands each
// accepted 16-bit instruction into one or more control words and latches the final ALU flags.
module dp_sequencer #(
    parameter logic [3:0] FS_ADD = 4'b0010,
    parameter logic [3:0] FS_SUB = 4'b0101,
    parameter logic [3:0] FS_SHL = 4'b1110,
    parameter logic [3:0] FS_TRB = 4'b1100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic [15:0] CTRWRD,
    output logic [15:0] CONST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [3:0]  FLAGS,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        SHIFT = 3'd2,
        MCLR  = 3'd3,
        MADD  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_ALU  = 3'b001;
    localparam logic [2:0] OPC_ALUI = 3'b010;
    localparam logic [2:0] OPC_LOAD = 3'b011;
    localparam logic [2:0] OPC_SHL  = 3'b100;
    localparam logic [2:0] OPC_CMP  = 3'b101;
    localparam logic [2:0] OPC_MULK = 3'b110;
    localparam logic [2:0] OPC_BAD  = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, err_q;
    logic [3:0]  flags_q;
    logic        load, finish, fault_exit, flag_upd, shl_first;

    logic [2:0] in_opc, in_dr, in_sa;
    logic [3:0] in_fn;
    logic [2:0] opc, dr, sa, sb;
    logic [3:0] fn;

    assign {in_opc, in_dr, in_sa} = INSTR[15:7];
    assign in_fn                  = INSTR[3:0];
    assign {opc, dr, sa, sb, fn}  = instr_q;

    // Handshake: INSTR_READY is high exactly in IDLE; an instruction is taken on a rising
    // edge with INSTR_VALID & INSTR_READY. Valid seen while busy is ignored and must be held.
    assign INSTR_READY = (state_q == IDLE);
    assign BUSY        = (state_q != IDLE);
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign FLAGS       = flags_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        finish     = 1'b0;
        fault_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (INSTR_VALID) begin
                    load = 1'b1;
                    case (in_opc)
                        OPC_SHL: begin
                            if (in_fn == 4'd0) begin
                                state_d = EXEC;
                            end else begin
                                state_d = SHIFT;
                                cnt_d   = in_fn - 4'd1;
                            end
                        end
                        OPC_MULK: begin
                            if (in_dr == in_sa) begin
                                state_d = FAULT;
                            end else begin
                                state_d = MCLR;
                                cnt_d   = in_fn;
                            end
                        end
                        OPC_BAD: state_d = FAULT;
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: finish = 1'b1;
            SHIFT, MADD: begin
                if (cnt_q == 4'd0) finish = 1'b1;
                else cnt_d = cnt_q - 4'd1;
            end
            MCLR: begin
                // MULK by zero ends right after the clearing pass.
                if (cnt_q == 4'd0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = MADD;
                end
            end
            FAULT: begin
                state_d    = IDLE;
                fault_exit = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (finish) state_d = IDLE;
    end

    assign flag_upd  = finish && (opc inside {OPC_ALU, OPC_ALUI, OPC_SHL, OPC_CMP, OPC_MULK});
    assign shl_first = (cnt_q == (fn - 4'd1));

    always_comb begin
        CTRWRD = 16'h0000;
        CONST  = 16'h0000;
        case (state_q)
            EXEC: begin
                case (opc)
                    OPC_ALU:  CTRWRD = {dr, sa, sb, 1'b0, fn, 2'b01};
                    OPC_ALUI: begin
                        CTRWRD = {dr, sa, 3'b000, 1'b1, fn, 2'b01};
                        CONST  = {13'h0000, sb};
                    end
                    OPC_LOAD: CTRWRD = {dr, sa, 3'b000, 1'b0, 4'b0000, 2'b11};
                    OPC_SHL:  CTRWRD = {dr, 3'b000, sb, 1'b0, FS_TRB, 2'b01};
                    OPC_CMP:  CTRWRD = {3'b000, sa, sb, 1'b0, FS_SUB, 2'b00};
                    default:  CTRWRD = 16'h0000;
                endcase
            end
            // First shift pass reads SB; later passes keep shifting DR in place.
            SHIFT:   CTRWRD = {dr, 3'b000, (shl_first ? sb : dr), 1'b0, FS_SHL, 2'b01};
            MCLR:    CTRWRD = {dr, sa, sa, 1'b0, FS_SUB, 2'b01};
            MADD:    CTRWRD = {dr, dr, sa, 1'b0, FS_ADD, 2'b01};
            default: CTRWRD = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            instr_q <= 16'h0000;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= finish;
            err_q   <= fault_exit;
            if (load) instr_q <= INSTR;
            if (flag_upd) flags_q <= {V, C, N, Z};
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: a behavioural register-file datapath closes the flag loop, a
// vector table covers the worked examples, and random instructions are checked against a model.
module tb_dp_sequencer;

    localparam logic [3:0] FS_ADD = 4'b0010;
    localparam logic [3:0] FS_SUB = 4'b0101;
    localparam logic [3:0] FS_SHL = 4'b1110;
    localparam logic [3:0] FS_TRB = 4'b1100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        V, C, N, Z;
    logic [15:0] CTRWRD;
    logic [15:0] CONST;
    logic        BUSY, DONE, ERR;
    logic [3:0]  FLAGS;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'h0;
    logic [15:0] a_bus, b_bus, d_bus;
    logic [19:0] alu_out;
    logic [3:0]  exp_flags;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] first_word;
        logic [15:0] first_const;
        int          cycles;
        logic        err;
    } vec_t;
    vec_t vecs[10];

    dp_sequencer dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .V(V), .C(C), .N(N), .Z(Z),
        .CTRWRD(CTRWRD), .CONST(CONST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .FLAGS(FLAGS), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Datapath function unit: returns {V, C, N, Z, F}.
    function automatic logic [19:0] alu(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] bb, f;
        logic        cin, arith;
        arith = 1'b1; bb = 16'h0; cin = 1'b0; f = 16'h0; s = 17'h0;
        case (fs)
            4'b0001: cin = 1'b1;
            4'b0010: bb = b;
            4'b0011: begin bb = b; cin = 1'b1; end
            4'b0100: bb = ~b;
            4'b0101: begin bb = ~b; cin = 1'b1; end
            4'b0110: bb = 16'hFFFF;
            default: arith = 1'b0;
        endcase
        if (arith) begin
            s = {1'b0, a} + {1'b0, bb} + {16'h0, cin};
            f = s[15:0];
            return {(a[15] == bb[15]) && (f[15] != a[15]), s[16], f[15], f == 16'h0, f};
        end
        case (fs)
            4'b0000, 4'b0111: f = a;
            4'b1000: f = a & b;
            4'b1001: f = a | b;
            4'b1010: f = a ^ b;
            4'b1011: f = ~a;
            4'b1100: f = b;
            4'b1101: f = b >> 1;
            4'b1110: f = b << 1;
            default: f = 16'h0;
        endcase
        return {1'b0, 1'b0, f[15], f == 16'h0, f};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] addr);
        return addr ^ 16'h5A5A;
    endfunction

    always_comb begin
        a_bus   = rf[CTRWRD[12:10]];
        b_bus   = CTRWRD[6] ? CONST : rf[CTRWRD[9:7]];
        alu_out = alu(CTRWRD[5:2], a_bus, b_bus);
        d_bus   = CTRWRD[1] ? mem_rd(a_bus) : alu_out[15:0];
    end
    assign {V, C, N, Z} = alu_out[19:16];

    always @(posedge CLK) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (CTRWRD[0]) rf[CTRWRD[15:13]] <= d_bus;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // Called at a negedge; issues one instruction and checks it through its DONE/ERR cycle.
    task automatic run_instr(input logic [15:0] instr, output logic [15:0] first_word,
                             output logic [15:0] first_const, output int cycles, output logic saw_err);
        logic [2:0]  opc, dr, sa, sb;
        logic [3:0]  fn, fval;
        logic [15:0] snap [8];
        logic [15:0] exp_rf [8];
        logic [15:0] exp_const;
        logic [19:0] r;
        logic        fupd, fault;
        int          waited;
        {opc, dr, sa, sb, fn} = instr;
        first_word = 16'h0; first_const = 16'h0; cycles = 0; saw_err = 1'b0;
        waited = 0;
        while (!INSTR_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!INSTR_READY) chk("ready_timeout", {31'h0, INSTR_READY}, 32'h1);
        for (int i = 0; i < 8; i++) snap[i] = rf[i];
        exp_rf = snap;
        fupd = 1'b0; fault = 1'b0; fval = 4'h0; exp_const = 16'h0;
        exp_q.delete();
        case (opc)
            3'b000: exp_q.push_back(16'h0000);
            3'b001: begin
                exp_q.push_back({dr, sa, sb, 1'b0, fn, 2'b01});
                r = alu(fn, snap[sa], snap[sb]);
                exp_rf[dr] = r[15:0]; fupd = 1'b1; fval = r[19:16];
            end
            3'b010: begin
                exp_q.push_back({dr, sa, 3'b000, 1'b1, fn, 2'b01});
                exp_const = {13'h0, sb};
                r = alu(fn, snap[sa], exp_const);
                exp_rf[dr] = r[15:0]; fupd = 1'b1; fval = r[19:16];
            end
            3'b011: begin
                exp_q.push_back({dr, sa, 3'b000, 1'b0, 4'b0000, 2'b11});
                exp_rf[dr] = mem_rd(snap[sa]);
            end
            3'b100: begin
                if (fn == 4'd0) exp_q.push_back({dr, 3'b000, sb, 1'b0, FS_TRB, 2'b01});
                for (int i = 0; i < int'(fn); i++)
                    exp_q.push_back({dr, 3'b000, (i == 0) ? sb : dr, 1'b0, FS_SHL, 2'b01});
                exp_rf[dr] = snap[sb] << fn;
                fupd = 1'b1; fval = {2'b00, exp_rf[dr][15], exp_rf[dr] == 16'h0};
            end
            3'b101: begin
                exp_q.push_back({3'b000, sa, sb, 1'b0, FS_SUB, 2'b00});
                r = alu(FS_SUB, snap[sa], snap[sb]);
                fupd = 1'b1; fval = r[19:16];
            end
            3'b110: begin
                if (dr == sa) begin
                    fault = 1'b1;
                    exp_q.push_back(16'h0000);
                end else begin
                    exp_q.push_back({dr, sa, sa, 1'b0, FS_SUB, 2'b01});
                    for (int i = 0; i < int'(fn); i++) exp_q.push_back({dr, dr, sa, 1'b0, FS_ADD, 2'b01});
                    exp_rf[dr] = 16'(snap[sa] * fn);
                    fupd = 1'b1;
                    if (fn == 4'd0) begin
                        fval = 4'b0101;
                    end else begin
                        r = alu(FS_ADD, 16'(snap[sa] * (fn - 4'd1)), snap[sa]);
                        fval = r[19:16];
                    end
                end
            end
            default: begin
                fault = 1'b1;
                exp_q.push_back(16'h0000);
            end
        endcase
        INSTR = instr;
        INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        INSTR = 16'($urandom);
        while (BUSY && cycles < 40) begin
            if (exp_q.size() == 0) chk("extra_busy_cycle", {16'h0, CTRWRD}, 32'h0);
            else chk("ctrwrd", {16'h0, CTRWRD}, {16'h0, exp_q.pop_front()});
            chk("const", {16'h0, CONST}, {16'h0, exp_const});
            chk("ready_while_busy", {31'h0, INSTR_READY}, 32'h0);
            chk("pulse_while_busy", {30'h0, DONE, ERR}, 32'h0);
            if (cycles == 0) begin
                first_word = CTRWRD;
                first_const = CONST;
            end
            cycles++;
            @(negedge CLK);
        end
        chk("busy_bounded", {31'h0, BUSY}, 32'h0);
        chk("words_missing", exp_q.size(), 32'h0);
        saw_err = ERR;
        chk("done_pulse", {31'h0, DONE}, {31'h0, !fault});
        chk("err_pulse", {31'h0, ERR}, {31'h0, fault});
        chk("ready_after", {31'h0, INSTR_READY}, 32'h1);
        chk("ctrwrd_idle", {16'h0, CTRWRD}, 32'h0);
        if (fupd) exp_flags = fval;
        chk("flags", {28'h0, FLAGS}, {28'h0, exp_flags});
        for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), {16'h0, rf[i]}, {16'h0, exp_rf[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] fw, fc;
        int          cy;
        logic        er;
        vecs[0] = '{16'h2532, 16'h2989, 16'h0000, 1, 1'b0};
        vecs[1] = '{16'h50D2, 16'h8449, 16'h0005, 1, 1'b0};
        vecs[2] = '{16'hD503, 16'hA915, 16'h0000, 4, 1'b0};
        vecs[3] = '{16'hC903, 16'h0000, 16'h0000, 1, 1'b1};
        vecs[4] = '{16'h9834, 16'hC1B9, 16'h0000, 4, 1'b0};
        vecs[5] = '{16'h9C30, 16'hE1B1, 16'h0000, 1, 1'b0};
        vecs[6] = '{16'hA520, 16'h0914, 16'h0000, 1, 1'b0};
        vecs[7] = '{16'hE000, 16'h0000, 16'h0000, 1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
        vecs[9] = '{16'h7D00, 16'hE803, 16'h0000, 1, 1'b0};

        INSTR = 16'h0; INSTR_VALID = 1'b0; RESET = 1'b0; exp_flags = 4'h0;
        repeat (3) @(negedge CLK);
        chk("rst_ctrwrd", {16'h0, CTRWRD}, 32'h0);
        chk("rst_const", {16'h0, CONST}, 32'h0);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_pulses", {30'h0, DONE, ERR}, 32'h0);
        chk("rst_flags", {28'h0, FLAGS}, 32'h0);
        chk("rst_ready", {31'h0, INSTR_READY}, 32'h1);
        chk("rst_state", {29'h0, dbg_state}, 32'h0);
        RESET = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
        preload(3'd2, 16'd7);
        preload(3'd3, 16'd1);

        for (int t = 0; t < 10; t++) begin
            run_instr(vecs[t].instr, fw, fc, cy, er);
            chk($sformatf("vec%0d_first_word", t), {16'h0, fw}, {16'h0, vecs[t].first_word});
            chk($sformatf("vec%0d_first_const", t), {16'h0, fc}, {16'h0, vecs[t].first_const});
            chk($sformatf("vec%0d_cycles", t), cy, vecs[t].cycles);
            chk($sformatf("vec%0d_err", t), {31'h0, er}, {31'h0, vecs[t].err});
        end
        chk("plan_r1", {16'h0, rf[1]}, 32'd8);
        chk("plan_r4", {16'h0, rf[4]}, 32'd13);
        chk("plan_r5", {16'h0, rf[5]}, 32'd21);
        chk("plan_r6", {16'h0, rf[6]}, 32'h10);
        chk("plan_cmp_flags", {28'h0, FLAGS}, 32'h5);

        // Valid held high through the busy cycle with a new instruction waiting.
        INSTR = 16'h50D2; INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR = 16'h2532;
        chk("hold_ctrwrd", {16'h0, CTRWRD}, 32'h8449);
        chk("hold_const", {16'h0, CONST}, 32'h5);
        chk("hold_ready", {31'h0, INSTR_READY}, 32'h0);
        @(negedge CLK);
        chk("hold_done", {31'h0, DONE}, 32'h1);
        chk("hold_ready_done", {31'h0, INSTR_READY}, 32'h1);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        chk("hold_second_word", {16'h0, CTRWRD}, 32'h2989);
        @(negedge CLK);
        chk("hold_second_done", {31'h0, DONE}, 32'h1);
        chk("hold_r1", {16'h0, rf[1]}, 32'd8);
        chk("hold_flags", {28'h0, FLAGS}, 32'h0);

        // Reset during the second MADD pass of MULK R5=R2*3.
        INSTR = 16'hD503; INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        chk("rmid_mclr", {16'h0, CTRWRD}, 32'hA915);
        @(negedge CLK);
        chk("rmid_madd1", {16'h0, CTRWRD}, 32'hB509);
        @(negedge CLK);
        chk("rmid_madd2", {16'h0, CTRWRD}, 32'hB509);
        #2 RESET = 1'b0;
        #1;
        chk("rmid_ctrwrd", {16'h0, CTRWRD}, 32'h0);
        chk("rmid_busy", {31'h0, BUSY}, 32'h0);
        chk("rmid_state", {29'h0, dbg_state}, 32'h0);
        chk("rmid_flags", {28'h0, FLAGS}, 32'h0);
        @(negedge CLK);
        chk("rmid_no_done", {30'h0, DONE, ERR}, 32'h0);
        chk("rmid_r5", {16'h0, rf[5]}, 32'd7);
        RESET = 1'b1;
        exp_flags = 4'h0;
        @(negedge CLK);
        run_instr(16'h2532, fw, fc, cy, er);
        chk("rmid_next_word", {16'h0, fw}, 32'h2989);

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_instr(16'($urandom), fw, fc, cy, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
